sevenseg_demux: RTL and testbench

Receive-side decoder for the four-digit multiplexed seven-segment bus (`an`, `seg`, `dp`, all active-low, `seg[6:0]` = a..g). It samples the scanned bus and reconstructs the per-digit hex value, blank state and decimal point. It then reports complete display frames. It sits on a loopback or probe path behind the display driver, so the shot clock value can be checked on-board or forwarded to a monitor.

---
 rtl/sevenseg_pkg.sv | 67 ++++++
 rtl/sevenseg_demux_if.sv | 15 +
 rtl/sevenseg_pattern_decode.sv | 43 ++++
 rtl/sevenseg_demux.sv | 163 ++++++++++++++++
 tb/tb_sevenseg_demux.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared seven-segment constants, dwell class and helpers
//
// Segment patterns are active-low, seg[6:0] = a..g. Used by the receive-side
// decoder (sevenseg_demux) and the display encoder.
//   SEG_0..SEG_F   legal hex glyphs
//   SEG_BLANK      all segments off (legal, captured as a blank digit)
//   dwell_t        classification of one settled bus dwell
//   classify_dwell anode/legality -> dwell_t
//   anode_slot     index of the low anode bit
package sevenseg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_NONE   = 4'b1111;

   typedef enum logic [1:0] {
      DW_IDLE   = 2'd0,
      DW_DIGIT  = 2'd1,
      DW_MULTI  = 2'd2,
      DW_BADSEG = 2'd3
   } dwell_t;

   function automatic dwell_t classify_dwell(input logic [3:0] an, input logic seg_legal);
      int     lit;
      dwell_t cls;
      lit = $countones(~an);
      if (lit == 0) begin
         cls = DW_IDLE;
      end else if (lit > 1) begin
         cls = DW_MULTI;
      end else if (seg_legal) begin
         cls = DW_DIGIT;
      end else begin
         cls = DW_BADSEG;
      end
      return cls;
   endfunction

   // Only meaningful when exactly one anode is low.
   function automatic logic [1:0] anode_slot(input logic [3:0] an);
      logic [1:0] idx;
      idx = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (!an[k]) begin
            idx = 2'(k);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/sevenseg_demux_if.sv
// rtl/sevenseg_demux_if.sv - multiplexed seven-segment bus interface
//
// Signals (all active-low):
//   an[3:0]   anode enables
//   seg[6:0]  segments a..g
//   dp        decimal point
// Modports: master drives the bus (display driver), slave observes it (decoder).
interface sevenseg_demux_if;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (output an, output seg, output dp);
   modport slave  (input an, input seg, input dp);
endinterface

// File: rtl/sevenseg_pattern_decode.sv
// rtl/sevenseg_pattern_decode.sv - combinational seven-segment glyph decoder
//
// Ports:
//   seg[6:0]     active-low segment pattern, a..g
//   legal        pattern is one of the 16 hex glyphs or all-off
//   blank        pattern is all-off
//   nibble[3:0]  hex value of the glyph (0 for blank or illegal)
module sevenseg_pattern_decode
   import sevenseg_pkg::*;
(
   input  logic [6:0] seg,
   output logic       legal,
   output logic       blank,
   output logic [3:0] nibble
);

   always_comb begin
      legal  = 1'b1;
      blank  = 1'b0;
      nibble = 4'h0;
      case (seg)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
         SEG_BLANK: blank  = 1'b1;
         default:   legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/sevenseg_demux.sv
// rtl/sevenseg_demux.sv - receive-side decoder for a four-digit multiplexed seven-segment bus
//
// Samples the scanned bus through a two-flop synchronizer, waits for each dwell to
// settle, and rebuilds per-digit hex value, blank state and decimal point, reporting
// complete frames. Optional stale-display watchdog: define SEVENSEG_DEMUX_TIMEOUT_EN.
//
// Parameters:
//   SETTLE_CYCLES   identical samples needed before a dwell is evaluated (2..255)
//   TIMEOUT_CYCLES  watchdog period in clocks (watchdog build only)
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   bus           sevenseg_demux_if.slave: an[3:0], seg[6:0], dp (active-low)
//   digit[15:0]   captured hex codes, nibble i belongs to anode i
//   blank[3:0]    digit i captured with all segments off
//   dp_on[3:0]    digit i captured with its decimal point lit
//   frame_pulse   one cycle when all four digits captured since the last pulse
//   err_pulse     one cycle on an illegal dwell
//   stale         watchdog flag, constant 0 without SEVENSEG_DEMUX_TIMEOUT_EN
module sevenseg_demux
   import sevenseg_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic            clk,
   input  logic            rst_n,
   sevenseg_demux_if.slave bus,
   output logic [15:0]     digit,
   output logic [3:0]      blank,
   output logic [3:0]      dp_on,
   output logic            frame_pulse,
   output logic            err_pulse,
   output logic            stale
);

   localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE_CYCLES);
   localparam logic [7:0]  EVAL_AT    = 8'(SETTLE_CYCLES - 1);
   localparam logic [11:0] WORD_IDLE  = 12'hFFF;

   logic [11:0] sync1;
   logic [11:0] sync2;
   logic [11:0] prev_word;
   logic [7:0]  stable_cnt;
   logic        word_changed;
   logic        evaluate;

   logic [3:0]  w_an;
   logic [6:0]  w_seg;
   logic        w_dp;

   logic        pat_legal;
   logic        pat_blank;
   logic [3:0]  pat_nibble;

   dwell_t      dwell;
   logic [1:0]  slot;
   logic        capture;
   logic        dwell_err;
   logic        frame_done;
   logic [3:0]  seen;
   logic [3:0]  seen_next;

   assign {w_an, w_seg, w_dp} = sync2;

   // Synchronizer, previous-word register and stability counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= WORD_IDLE;
         sync2      <= WORD_IDLE;
         prev_word  <= WORD_IDLE;
         stable_cnt <= 8'd0;
      end else begin
         sync1     <= {bus.an, bus.seg, bus.dp};
         sync2     <= sync1;
         prev_word <= sync2;
         if (word_changed) begin
            stable_cnt <= 8'd0;
         end else if (stable_cnt != SETTLE_MAX) begin
            stable_cnt <= stable_cnt + 8'd1;
         end
      end
   end

   assign word_changed = (sync2 != prev_word);

   // The word in sync1 must also agree, so a dwell has to last SETTLE_CYCLES+2
   // bus clocks to be seen; shorter dwells drop out here without any report.
   // The counter passes EVAL_AT only once per dwell, so evaluation is single-shot.
   assign evaluate = !word_changed && (stable_cnt == EVAL_AT) && (sync1 == sync2);

   sevenseg_pattern_decode u_decode (
      .seg    (w_seg),
      .legal  (pat_legal),
      .blank  (pat_blank),
      .nibble (pat_nibble)
   );

   always_comb begin
      dwell      = classify_dwell(w_an, pat_legal);
      slot       = anode_slot(w_an);
      capture    = evaluate && (dwell == DW_DIGIT);
      dwell_err  = evaluate && ((dwell == DW_MULTI) || (dwell == DW_BADSEG));
      seen_next  = seen | (4'b0001 << slot);
      frame_done = capture && (seen_next == 4'b1111);
   end

`ifdef SEVENSEG_DEMUX_TIMEOUT_EN
   localparam int             WD_W       = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_FIRE_AT = WD_W'(TIMEOUT_CYCLES - 2);

   logic [WD_W-1:0] wd_cnt;
   logic            wd_fire;

   // Fires on the clock where the counter steps onto its last value.
   assign wd_fire = !capture && (wd_cnt == WD_FIRE_AT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
         stale  <= 1'b0;
      end else if (capture) begin
         wd_cnt <= '0;
         stale  <= 1'b0;
      end else if (wd_cnt != WD_LAST) begin
         wd_cnt <= wd_cnt + WD_W'(1);
         if (wd_fire) begin
            stale <= 1'b1;
         end
      end
   end
`else
   assign stale = 1'b0;
`endif

   // Capture registers and frame tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit       <= 16'h0000;
         blank       <= 4'b1111;
         dp_on       <= 4'b0000;
         seen        <= 4'b0000;
         frame_pulse <= 1'b0;
         err_pulse   <= 1'b0;
      end else begin
         frame_pulse <= frame_done;
         err_pulse   <= dwell_err;
         if (capture) begin
            digit[{slot, 2'b00} +: 4] <= pat_nibble;
            blank[slot]               <= pat_blank;
            dp_on[slot]               <= ~w_dp;
            seen                      <= frame_done ? 4'b0000 : seen_next;
         end
`ifdef SEVENSEG_DEMUX_TIMEOUT_EN
         else if (wd_fire) begin
            blank <= 4'b1111;
            seen  <= 4'b0000;
         end
`endif
      end
   end

endmodule

// File: tb/tb_sevenseg_demux.sv
// tb/tb_sevenseg_demux.sv - self-checking bench for sevenseg_demux
module tb_sevenseg_demux;

   localparam int S = 4;
`ifdef SEVENSEG_DEMUX_TIMEOUT_EN
   localparam int T = 64;
`else
   localparam int T = 1048576;
`endif

   localparam logic [6:0] SEG_TABLE [0:15] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };
   localparam logic [6:0] ALL_OFF = 7'b1111111;

   logic        clk;
   logic        rst_n;
   logic [15:0] digit;
   logic [3:0]  blank;
   logic [3:0]  dp_on;
   logic        frame_pulse;
   logic        err_pulse;
   logic        stale;

   sevenseg_demux_if bus_if ();

   sevenseg_demux #(
      .SETTLE_CYCLES  (S),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_if.slave),
      .digit       (digit),
      .blank       (blank),
      .dp_on       (dp_on),
      .frame_pulse (frame_pulse),
      .err_pulse   (err_pulse),
      .stale       (stale)
   );

   int checks = 0;
   int fails  = 0;

   logic [15:0] exp_digit;
   logic [3:0]  exp_blank;
   logic [3:0]  exp_dp;
   logic [3:0]  exp_seen;
   int          exp_frames = 0;
   int          exp_errs   = 0;
   int          frames_seen = 0;
   int          errs_seen   = 0;
   int          both_seen   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (frame_pulse) frames_seen++;
      if (err_pulse) errs_seen++;
      if (frame_pulse && err_pulse) both_seen++;
   end

   task automatic seg_lookup(input logic [6:0] s, output bit legal, output bit blk, output logic [3:0] nib);
      legal = 1'b0;
      blk   = 1'b0;
      nib   = 4'h0;
      if (s == ALL_OFF) begin
         legal = 1'b1;
         blk   = 1'b1;
      end
      for (int v = 0; v < 16; v++) begin
         if (SEG_TABLE[v] == s) begin
            legal = 1'b1;
            nib   = 4'(v);
         end
      end
   endtask

   // Reference behaviour of one isolated dwell held for n clocks.
   task automatic model_dwell(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
      bit         legal;
      bit         blk;
      logic [3:0] nib;
      int         lows;
      int         idx;
      if (n < S + 2) return;
      lows = 0;
      idx  = 0;
      for (int k = 0; k < 4; k++) begin
         if (!a[k]) begin
            lows++;
            idx = k;
         end
      end
      if (lows == 0) return;
      if (lows > 1) begin
         exp_errs++;
         return;
      end
      seg_lookup(s, legal, blk, nib);
      if (!legal) begin
         exp_errs++;
         return;
      end
      exp_digit[idx*4 +: 4] = nib;
      exp_blank[idx]        = blk;
      exp_dp[idx]           = ~d;
      exp_seen[idx]         = 1'b1;
      if (exp_seen == 4'b1111) begin
         exp_frames++;
         exp_seen = 4'b0000;
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
      @(negedge clk);
      bus_if.an  = a;
      bus_if.seg = s;
      bus_if.dp  = d;
      repeat (n - 1) @(negedge clk);
      model_dwell(a, s, d, n);
   endtask

   task automatic idle(input int n);
      drive(4'b1111, ALL_OFF, 1'b1, n);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus_if.an  = 4'b1111;
      bus_if.seg = ALL_OFF;
      bus_if.dp  = 1'b1;
      rst_n      = 1'b0;
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      exp_digit = 16'h0000;
      exp_blank = 4'b1111;
      exp_dp    = 4'b0000;
      exp_seen  = 4'b0000;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      bus_if.an  = 4'b1111;
      bus_if.seg = ALL_OFF;
      bus_if.dp  = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (digit !== 16'h0000) begin fails++; $display("FAIL reset_digit: got %h want 0000", digit); end
      checks++; if (blank !== 4'b1111) begin fails++; $display("FAIL reset_blank: got %b want 1111", blank); end
      checks++; if (dp_on !== 4'b0000) begin fails++; $display("FAIL reset_dp_on: got %b want 0000", dp_on); end
      checks++; if (frame_pulse !== 1'b0) begin fails++; $display("FAIL reset_frame: got %b want 0", frame_pulse); end
      checks++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_pulse); end
      checks++; if (stale !== 1'b0) begin fails++; $display("FAIL reset_stale: got %b want 0", stale); end
      rst_n     = 1'b1;
      exp_digit = 16'h0000;
      exp_blank = 4'b1111;
      exp_dp    = 4'b0000;
      exp_seen  = 4'b0000;
   endtask

   task automatic test_frame();
      int f0;
      int e0;
      do_reset();
      f0 = frames_seen;
      e0 = errs_seen;
      drive(4'b0111, SEG_TABLE[15], 1'b1, 8);
      drive(4'b1011, SEG_TABLE[15], 1'b1, 8);
      drive(4'b1101, SEG_TABLE[2], 1'b1, 8);
      drive(4'b1110, SEG_TABLE[4], 1'b1, 8);
      idle(4);
      checks++; if (digit !== 16'hFF24) begin fails++; $display("FAIL frame_digit: got %h want FF24", digit); end
      checks++; if (blank !== 4'b0000) begin fails++; $display("FAIL frame_blank: got %b want 0000", blank); end
      checks++; if (frames_seen - f0 !== 1) begin fails++; $display("FAIL frame_count: got %0d want 1", frames_seen - f0); end
      checks++; if (errs_seen - e0 !== 0) begin fails++; $display("FAIL frame_err: got %0d want 0", errs_seen - e0); end
   endtask

   task automatic test_settle();
      do_reset();
      drive(4'b1110, SEG_TABLE[5], 1'b1, 8);
      idle(4);
      drive(4'b1110, SEG_TABLE[0], 1'b1, 5);
      idle(4);
      checks++; if (digit[3:0] !== 4'h5) begin fails++; $display("FAIL settle_short: got %h want 5", digit[3:0]); end
      // Bus value present from edge E (the next posedge) for exactly six edges.
      @(negedge clk);
      bus_if.an  = 4'b1110;
      bus_if.seg = SEG_TABLE[0];
      bus_if.dp  = 1'b1;
      repeat (6) @(negedge clk);
      checks++; if (digit[3:0] !== 4'h5) begin fails++; $display("FAIL settle_early: got %h want 5 after E+5", digit[3:0]); end
      bus_if.an  = 4'b1111;
      bus_if.seg = ALL_OFF;
      @(negedge clk);
      checks++; if (digit[3:0] !== 4'h0) begin fails++; $display("FAIL settle_edge: got %h want 0 after E+6", digit[3:0]); end
      model_dwell(4'b1110, SEG_TABLE[0], 1'b1, 6);
      idle(3);
   endtask

   task automatic test_multi();
      int e0;
      e0 = errs_seen;
      drive(4'b1100, SEG_TABLE[$urandom_range(0, 15)], 1'b1, 20);
      idle(4);
      checks++; if (errs_seen - e0 !== 1) begin fails++; $display("FAIL multi_err: got %0d want 1", errs_seen - e0); end
      checks++; if (digit !== exp_digit) begin fails++; $display("FAIL multi_digit: got %h want %h", digit, exp_digit); end
   endtask

   task automatic test_badseg();
      int f0;
      int e0;
      do_reset();
      f0 = frames_seen;
      e0 = errs_seen;
      drive(4'b0111, 7'b1010101, 1'b1, 8);
      drive(4'b1011, SEG_TABLE[1], 1'b1, 8);
      drive(4'b1101, SEG_TABLE[2], 1'b1, 8);
      drive(4'b1110, SEG_TABLE[3], 1'b1, 8);
      idle(4);
      checks++; if (errs_seen - e0 !== 1) begin fails++; $display("FAIL badseg_err: got %0d want 1", errs_seen - e0); end
      checks++; if (frames_seen - f0 !== 0) begin fails++; $display("FAIL badseg_noframe: got %0d want 0", frames_seen - f0); end
      checks++; if (blank[3] !== 1'b1) begin fails++; $display("FAIL badseg_slot: got blank3 %b want 1", blank[3]); end
      drive(4'b0111, SEG_TABLE[9], 1'b0, 8);
      idle(4);
      checks++; if (frames_seen - f0 !== 1) begin fails++; $display("FAIL badseg_frame: got %0d want 1", frames_seen - f0); end
      checks++; if (digit !== 16'h9123) begin fails++; $display("FAIL badseg_digit: got %h want 9123", digit); end
      checks++; if (dp_on !== 4'b1000) begin fails++; $display("FAIL badseg_dp: got %b want 1000", dp_on); end
   endtask

   task automatic test_blank_dp();
      drive(4'b1101, SEG_TABLE[7], 1'b1, 8);
      idle(3);
      drive(4'b1101, ALL_OFF, 1'b0, 8);
      idle(4);
      checks++; if (blank[1] !== 1'b1) begin fails++; $display("FAIL blank_bit: got %b want 1", blank[1]); end
      checks++; if (dp_on[1] !== 1'b1) begin fails++; $display("FAIL blank_dp: got %b want 1", dp_on[1]); end
      checks++; if (digit[7:4] !== 4'h0) begin fails++; $display("FAIL blank_nibble: got %h want 0", digit[7:4]); end
   endtask

   task automatic test_random();
      logic [3:0] a;
      logic [6:0] s;
      logic       d;
      int         kind;
      int         n;
      int         k;
      for (int it = 0; it < 150; it++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            a = 4'b1111;
         end else if (kind <= 2) begin
            a = 4'($urandom_range(0, 15));
            while ($countones(~a) < 2) a = 4'($urandom_range(0, 15));
         end else begin
            a    = 4'b1111;
            k    = $urandom_range(0, 3);
            a[2'(k)] = 1'b0;
         end
         kind = $urandom_range(0, 9);
         if (kind < 7) s = SEG_TABLE[$urandom_range(0, 15)];
         else if (kind == 7) s = ALL_OFF;
         else s = 7'($urandom_range(0, 127));
         d = 1'($urandom_range(0, 1));
         n = $urandom_range(2, 10);
         drive(a, s, d, n);
         idle(3);
         checks++; if (digit !== exp_digit) begin fails++; $display("FAIL rand_digit it%0d: got %h want %h", it, digit, exp_digit); end
         checks++; if (blank !== exp_blank) begin fails++; $display("FAIL rand_blank it%0d: got %b want %b", it, blank, exp_blank); end
         checks++; if (dp_on !== exp_dp) begin fails++; $display("FAIL rand_dp it%0d: got %b want %b", it, dp_on, exp_dp); end
         checks++; if (frames_seen !== exp_frames) begin fails++; $display("FAIL rand_frames it%0d: got %0d want %0d", it, frames_seen, exp_frames); end
         checks++; if (errs_seen !== exp_errs) begin fails++; $display("FAIL rand_errs it%0d: got %0d want %0d", it, errs_seen, exp_errs); end
      end
      checks++; if (both_seen !== 0) begin fails++; $display("FAIL pulse_overlap: got %0d want 0", both_seen); end
`ifndef SEVENSEG_DEMUX_TIMEOUT_EN
      checks++; if (stale !== 1'b0) begin fails++; $display("FAIL stale_off: got %b want 0", stale); end
`endif
   endtask

   task automatic test_midreset();
      do_reset();
      drive(4'b1101, SEG_TABLE[8], 1'b1, 8);
      idle(3);
      @(negedge clk);
      bus_if.an  = 4'b1110;
      bus_if.seg = SEG_TABLE[6];
      bus_if.dp  = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (digit !== 16'h0000) begin fails++; $display("FAIL midreset_digit: got %h want 0000", digit); end
      checks++; if (blank !== 4'b1111) begin fails++; $display("FAIL midreset_blank: got %b want 1111", blank); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (digit !== 16'h0000) begin fails++; $display("FAIL midreset_early: got %h want 0000", digit); end
      repeat (10) @(negedge clk);
      checks++; if (digit !== 16'h0006) begin fails++; $display("FAIL midreset_capture: got %h want 0006", digit); end
      checks++; if (blank !== 4'b1110) begin fails++; $display("FAIL midreset_blank2: got %b want 1110", blank); end
      idle(3);
      exp_digit = 16'h0006;
      exp_blank = 4'b1110;
      exp_dp    = 4'b0000;
      exp_seen  = 4'b0001;
   endtask

`ifdef SEVENSEG_DEMUX_TIMEOUT_EN
   task automatic test_timeout();
      int waited;
      waited = 0;
      do_reset();
      drive(4'b1110, SEG_TABLE[3], 1'b1, 8);
      idle(1);
      while (stale !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checks++; if (stale !== 1'b1) begin fails++; $display("FAIL timeout_stale: got %b want 1", stale); end
      checks++; if (waited < 50 || waited > 70) begin fails++; $display("FAIL timeout_time: got %0d want 50..70", waited); end
      checks++; if (blank !== 4'b1111) begin fails++; $display("FAIL timeout_blank: got %b want 1111", blank); end
      drive(4'b1101, SEG_TABLE[4], 1'b1, 8);
      idle(1);
      checks++; if (stale !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %b want 0", stale); end
   endtask
`endif

   initial begin
      test_reset();
      test_frame();
      test_settle();
      test_multi();
      test_badseg();
      test_blank_dp();
      test_midreset();
      test_random();
`ifdef SEVENSEG_DEMUX_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
